mult4_accumulator: RTL and testbench
====================================

MULT4_ACCUMULATOR -- requirements
Module: mult4_accumulator

Interface
REQ-001 The block SHALL have no parameters; all widths and limits SHALL come from the shared package (ACC_W=12, CNT_W=5, MAX_TERMS=16).
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 a  input  4  unsigned multiplicand.
REQ-008 b  input  4  unsigned multiplier.
REQ-009 in_last  input  1  final pair of the current frame.
REQ-010 out_valid  output  1  frame result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 acc_out  output  12  sum of the frame's a*b products.
REQ-013 count_out  output  5  number of pairs in the frame (1..16).

Function
REQ-014 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-015 Stage 1 SHALL register the 8-bit product a*b, a valid flag p_vld, and p_last = in_last OR (issued-beat counter == 15) on each accepted beat; p_vld SHALL be 0 on edges with no accepted beat.
REQ-016 Stage 2 SHALL, on each edge with p_vld=1, set acc <= acc + zero-extended product and cnt <= cnt + 1.
REQ-017 The FSM SHALL have two states: ACC (accumulating) and DONE (result held).
REQ-018 In ACC, when p_vld and p_last are both 1, the FSM SHALL move to DONE on the same edge that performs the final accumulation.
REQ-019 In DONE, when out_ready is 1, the FSM SHALL clear acc, cnt and the issued counter and return to ACC.
REQ-020 in_ready SHALL equal (state==ACC) AND NOT (p_vld AND p_last).
REQ-021 out_valid SHALL equal (state==DONE); acc_out and count_out SHALL show acc and cnt and SHALL stay stable while out_valid is 1.
REQ-022 Latency SHALL be exactly 2 edges: a last beat accepted at edge k gives out_valid=1 after edge k+1.
REQ-023 acc SHALL be 12 bits with no saturation, because the maximum sum 16*225=3600 is below 4096.
REQ-024 A frame SHALL close automatically on the 16th beat even when in_last=0; a 17th beat SHALL be held off by in_ready=0.
REQ-025 in_valid SHALL be ignored while in_ready=0, and a, b and in_last SHALL NOT be sampled then.
REQ-026 A zero-beat frame SHALL NOT exist; out_valid SHALL assert only after at least one accumulated beat.
REQ-027 The first beat of the next frame SHALL be acceptable on the edge after the out_valid/out_ready handshake.

Reset
REQ-028 When rst_n=0, all state SHALL clear immediately, independent of clk: state=ACC, acc=0, cnt=0, issued counter=0, p_vld=0, p_last=0, product register=0.
REQ-029 During reset, outputs SHALL be out_valid=0, acc_out=0 and count_out=0; in_ready SHALL read 1, and no beat SHALL be accepted while rst_n=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no result emitted.

Structure
REQ-031 Package mult4_acc_pkg SHALL hold ACC_W, CNT_W, MAX_TERMS and the state enumeration {ACC, DONE}.
REQ-032 The product SHALL be formed by one instance of the existing 4x4 array multiplier module bit4_multiplier driven by a and b; no other sub-modules SHALL be used.

Verification
REQ-033 Reset check: drive rst_n=0 mid-simulation -> out_valid=0, acc_out=0 and count_out=0 at once; after release in_ready=1.
REQ-034 Short frame: send (3,5), (15,15), (0,9,last) back-to-back -> acc_out=240, count_out=3, out_valid high 2 edges after the last beat.
REQ-035 Auto-close: send 16 beats of (15,15) with in_last=0 and in_valid held high -> acc_out=3600, count_out=16, in_ready=0 with no 17th beat accepted.
REQ-036 Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> acc_out and count_out stable, in_ready=0; raise out_ready -> next cycle in_ready=1 and out_valid=0.
REQ-037 Mid-frame reset: after 2 accepted beats, pulse rst_n low -> no result emitted; then send (2,3,last) -> acc_out=6, count_out=1.
REQ-038 Sparse input: send (1,1), idle 3 cycles, then (2,2,last) -> acc_out=5, count_out=2.

Source files
------------

// File: rtl/mult4_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult4_acc_pkg
//  Brief    : Shared widths, limits and FSM state encoding for the
//             4x4 multiply-accumulate frame engine.
//  Revision : 1.0  initial release
// ============================================================================
package mult4_acc_pkg;

    // Operand and product widths of the 4x4 multiplier
    localparam int OPND_W    = 4;
    localparam int PROD_W    = 8;

    // Accumulator width: 16 * 15 * 15 = 3600 fits in 12 bits, no saturation needed
    localparam int ACC_W     = 12;

    // Beat counter width: must represent 1..16
    localparam int CNT_W     = 5;

    // Maximum number of beats in one frame before it closes on its own
    localparam int MAX_TERMS = 16;

    // Frame FSM: accumulating beats, or holding a finished result
    typedef enum logic [0:0] {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

endpackage : mult4_acc_pkg
`default_nettype wire

// File: rtl/bit4_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : bit4_multiplier
//  Brief    : Combinational 4x4 unsigned array multiplier. Each row gates a
//             shifted copy of the multiplicand by one multiplier bit and adds
//             it to the running partial sum of the rows above.
//  Revision : 1.0  initial release
// ============================================================================
module bit4_multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    localparam int c_ROWS = 4;

    logic [7:0] w_pp  [c_ROWS];
    logic [7:0] w_sum [c_ROWS+1];

    assign w_sum[0] = 8'd0;

    // One array row per multiplier bit: partial product plus ripple into the sum
    for (genvar i = 0; i < c_ROWS; i++) begin : g_row
        assign w_pp[i]    = b[i] ? ({4'b0000, a} << i) : 8'd0;
        assign w_sum[i+1] = w_sum[i] + w_pp[i];
    end

    assign p = w_sum[c_ROWS];

endmodule : bit4_multiplier
`default_nettype wire

// File: rtl/mult4_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : mult4_accumulator
//  Brief    : Frames of up to 16 unsigned 4-bit operand pairs are multiplied
//             (stage 1) and summed (stage 2). A frame closes on in_last or on
//             its 16th beat; the sum and beat count are then held on
//             acc_out/count_out until the consumer accepts them.
//  Revision : 1.0  initial release
// ============================================================================
module mult4_accumulator
    import mult4_acc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  count_out
);

    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(MAX_TERMS - 1);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [PROD_W-1:0]   w_prod;
    logic                w_accept;
    logic                w_clear;
    logic                w_final_beat;

    logic [PROD_W-1:0]   r_prod;
    logic                r_p_vld;
    logic                r_p_last;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_issued;

    bit4_multiplier u_mult (
        .a (a),
        .b (b),
        .p (w_prod)
    );

    assign w_accept     = in_valid & in_ready;
    assign w_clear      = (r_state == DONE) & out_ready;
    // The final accumulation is in stage 2 this cycle; no new beat may enter behind it
    assign w_final_beat = r_p_vld & r_p_last;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: close on the final accumulation, reopen on result handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACC:     if (w_final_beat) w_state_nxt = DONE;
            DONE:    if (out_ready)    w_state_nxt = ACC;
            default: w_state_nxt = ACC;
        endcase
    end

    // FSM outputs: handshake flags derived from state and the stage-1 flags
    always_comb begin
        in_ready  = (r_state == ACC) & ~w_final_beat;
        out_valid = (r_state == DONE);
    end

    // Stage 1: register product and frame-end flag; last also forced on beat 16
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod   <= '0;
            r_p_vld  <= 1'b0;
            r_p_last <= 1'b0;
        end else begin
            r_p_vld <= w_accept;
            if (w_accept) begin
                r_prod   <= w_prod;
                r_p_last <= in_last | (r_issued == c_LAST_IDX);
            end
        end
    end

    // Issued-beat counter: counts accepted beats so the frame can auto-close
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued <= '0;
        end else if (w_clear) begin
            r_issued <= '0;
        end else if (w_accept) begin
            r_issued <= r_issued + c_CNT_ONE;
        end
    end

    // Stage 2: accumulate products and beat count; cleared when the result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_p_vld) begin
            r_acc <= r_acc + ACC_W'(r_prod);
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    assign acc_out   = r_acc;
    assign count_out = r_cnt;

endmodule : mult4_accumulator
`default_nettype wire

// File: tb/tb_mult4_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult4_accumulator
//  Brief    : Directed bench for mult4_accumulator. Stimulus pushes the
//             hand-computed frame result into a scoreboard queue; a monitor
//             pops and compares on every out_valid/out_ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult4_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  a = 4'd0;
    logic [3:0]  b = 4'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] acc_out;
    logic [4:0]  count_out;

    typedef struct packed {
        logic [11:0] acc;
        logic [4:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_seen   = 0;

    mult4_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    task automatic push_exp(input logic [11:0] acc, input logic [4:0] cnt);
        exp_t e;
        e.acc = acc;
        e.cnt = cnt;
        sb_q.push_back(e);
        n_pushed++;
    endtask

    // Present one beat and return 1 time unit after the edge that accepts it
    task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic tl);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        in_last  = tl;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) timeout_fail("send_accept");
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_seen(input int target);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge clk);
            #1;
            if (n_seen >= target) done = 1'b1;
        end
        if (!done) timeout_fail("wait_result");
    endtask

    // Scoreboard monitor: compare every accepted result against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                n_seen++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: acc=%0d cnt=%0d with nothing expected", acc_out, count_out);
                end else begin
                    e = sb_q.pop_front();
                    check("result_acc", 32'(acc_out), 32'(e.acc));
                    check("result_cnt", 32'(count_out), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- Reset state ----
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_acc_out",   32'(acc_out),   0);
        check("rst_count_out", 32'(count_out), 0);
        check("rst_in_ready",  32'(in_ready),  1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);

        // ---- Short frame: 15 + 225 + 0 = 240, three beats ----
        out_ready = 1'b1;
        push_exp(12'd240, 5'd3);
        send(4'd3,  4'd5,  1'b0);
        send(4'd15, 4'd15, 1'b0);
        send(4'd0,  4'd9,  1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("short_valid_edge_k",  32'(out_valid), 0);
        @(posedge clk);
        #1;
        check("short_valid_edge_k1", 32'(out_valid), 1);
        check("short_ready_in_done", 32'(in_ready),  0);
        @(posedge clk);
        #1;
        check("short_valid_cleared", 32'(out_valid), 0);
        check("short_next_ready",    32'(in_ready),  1);
        check("short_seen",          32'(n_seen),    1);

        // ---- Auto-close at 16 beats of 15*15, then back-pressure ----
        out_ready = 1'b0;
        push_exp(12'd3600, 5'd16);
        for (int i = 0; i < 16; i++) send(4'd15, 4'd15, 1'b0);
        // in_valid stays high: a 17th beat must be held off
        check("auto_ready_after_16", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        check("auto_out_valid", 32'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_acc_stable",  32'(acc_out),   3600);
            check("bp_cnt_stable",  32'(count_out), 16);
            check("bp_in_ready",    32'(in_ready),  0);
            check("bp_out_valid",   32'(out_valid), 1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready",  32'(in_ready),  1);
        check("bp_release_out_valid", 32'(out_valid), 0);
        check("bp_release_cnt_clear", 32'(count_out), 0);

        // ---- Mid-frame reset discards the partial frame ----
        send(4'd7, 4'd7, 1'b0);
        send(4'd7, 4'd7, 1'b0);
        idle(1);
        check("mid_partial_cnt", 32'(count_out), 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_acc_out",   32'(acc_out),   0);
        check("mid_rst_count_out", 32'(count_out), 0);
        check("mid_rst_in_ready",  32'(in_ready),  1);
        // A beat offered during reset must not be taken
        in_valid = 1'b1;
        a        = 4'd9;
        b        = 4'd9;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_no_beat_in_rst", 32'(count_out), 0);
        check("mid_no_result",      32'(out_valid), 0);
        push_exp(12'd6, 5'd1);
        send(4'd2, 4'd3, 1'b1);
        idle(0);
        wait_seen(n_pushed);

        // ---- Sparse input: 1 + 4 = 5, two beats ----
        push_exp(12'd5, 5'd2);
        send(4'd1, 4'd1, 1'b0);
        idle(3);
        send(4'd2, 4'd2, 1'b1);
        idle(0);
        wait_seen(n_pushed);

        // ---- Single-beat frame: 9 * 13 = 117 ----
        push_exp(12'd117, 5'd1);
        send(4'd9, 4'd13, 1'b1);
        idle(0);
        wait_seen(n_pushed);

        idle(3);
        check("sb_empty",     32'(sb_q.size()), 0);
        check("results_seen", 32'(n_seen),      32'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mult4_accumulator
`default_nettype wire
